// File: rtl/led_frame_scheduler_if.sv
// Signal bundle between the LED frame scheduler and the logic around it:
// two pixel-write requesters, clear/swap control, and the driver-facing
// scan strobes and front-buffer pixel planes.
interface led_frame_scheduler_if;
    // Requester A
    logic              A_valid;
    logic              A_ready;
    logic [3:0]        A_row;
    logic [3:0]        A_col;
    logic              A_red;
    logic              A_grn;
    // Requester B
    logic              B_valid;
    logic              B_ready;
    logic [3:0]        B_row;
    logic [3:0]        B_col;
    logic              B_red;
    logic              B_grn;
    // Frame control
    logic              Clear_req;
    logic              Swap_req;
    logic              Busy;
    logic              Swap_done;
    // Driver side
    logic              ScanEnable;
    logic              FrameStart;
    logic [15:0][15:0] RedPixels;
    logic [15:0][15:0] GrnPixels;

    // Requesters and controller drive requests and observe status
    modport master (
        output A_valid, A_row, A_col, A_red, A_grn,
        output B_valid, B_row, B_col, B_red, B_grn,
        output Clear_req, Swap_req,
        input  A_ready, B_ready, Busy, Swap_done,
        input  ScanEnable, FrameStart, RedPixels, GrnPixels
    );

    // The scheduler consumes requests and produces status and pixels
    modport slave (
        input  A_valid, A_row, A_col, A_red, A_grn,
        input  B_valid, B_row, B_col, B_red, B_grn,
        input  Clear_req, Swap_req,
        output A_ready, B_ready, Busy, Swap_done,
        output ScanEnable, FrameStart, RedPixels, GrnPixels
    );
endinterface

// File: rtl/led_frame_scheduler.sv
// Double-buffered frame controller for the 16x16 red/green LED driver.
// Two requesters write pixels into the back buffer through a round-robin
// arbiter; the front buffer is presented to the driver. Front and back only
// trade places on a frame boundary, so a half-drawn frame is never shown.
// The block also produces the driver's row-advance strobe (ScanEnable).
module led_frame_scheduler #(
    parameter int TICKDIV = 1000,   // cycles between ScanEnable pulses, >= 2
    parameter int FREQDIV = 0       // must match the driver's FREQDIV
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    led_frame_scheduler_if.slave  bus
);

    localparam int                TICK_W    = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKDIV - 1);
    // One pulse-counter wrap covers 16 rows of 2^FREQDIV pulses each.
    localparam int                PULSE_W   = FREQDIV + 4;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_CLEAR     = 2'd1;
    localparam logic [1:0] ST_WAIT_SWAP = 2'd2;
    localparam logic [1:0] ST_SWAP      = 2'd3;

    localparam logic LG_A = 1'b0;
    localparam logic LG_B = 1'b1;

    // Sequential state
    logic [1:0]         state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [PULSE_W-1:0] pulse_q, pulse_d;
    logic               front_q, front_d;      // 0: buf0 displayed, 1: buf1 displayed
    logic [3:0]         ptr_q, ptr_d;          // row being cleared
    logic               lg_q, lg_d;            // last granted requester
    logic               swap_pend_q, swap_pend_d;
    logic [15:0][15:0]  red0_q, red0_d;
    logic [15:0][15:0]  grn0_q, grn0_d;
    logic [15:0][15:0]  red1_q, red1_d;
    logic [15:0][15:0]  grn1_q, grn1_d;

    // Combinational helpers
    logic       scan_en;
    logic       frame_end;
    logic       idle;
    logic       grant_a;
    logic       grant_b;
    logic       wr_en;
    logic [3:0] wr_row;
    logic [3:0] wr_col;
    logic       wr_red;
    logic       wr_grn;

    assign scan_en   = (tick_q == TICK_LAST);
    assign frame_end = scan_en && (&pulse_q);
    assign idle      = (state_q == ST_IDLE);

    // Scan timing: tick counter paces ScanEnable, pulse counter marks the frame end
    always_comb begin
        // NOTE: every variable gets a value before any branch, so no path
        // through the block leaves it unassigned and no latch is inferred.
        tick_d  = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
        pulse_d = pulse_q;
        if (scan_en) begin
            pulse_d = pulse_q + PULSE_W'(1);
        end
    end

    // Round-robin arbiter: only in IDLE, one grant per cycle, ties go to the requester not last served
    always_comb begin
        grant_a = idle && bus.A_valid && (!bus.B_valid || (lg_q == LG_B));
        grant_b = idle && bus.B_valid && (!bus.A_valid || (lg_q == LG_A));
        wr_en   = grant_a || grant_b;
        wr_row  = grant_a ? bus.A_row : bus.B_row;
        wr_col  = grant_a ? bus.A_col : bus.B_col;
        wr_red  = grant_a ? bus.A_red : bus.B_red;
        wr_grn  = grant_a ? bus.A_grn : bus.B_grn;
        lg_d    = lg_q;
        if (grant_a) begin
            lg_d = LG_A;
        end else if (grant_b) begin
            lg_d = LG_B;
        end
    end

    // Frame control FSM: clear the back buffer row by row, swap only on a frame end
    always_comb begin
        state_d     = state_q;
        front_d     = front_q;
        ptr_d       = ptr_q;
        swap_pend_d = swap_pend_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.Clear_req) begin
                    // A swap requested alongside the clear runs once the clear is done.
                    state_d     = ST_CLEAR;
                    ptr_d       = 4'd0;
                    swap_pend_d = bus.Swap_req;
                end else if (bus.Swap_req) begin
                    state_d = ST_WAIT_SWAP;
                end
            end
            ST_CLEAR: begin
                ptr_d = ptr_q + 4'd1;
                if (ptr_q == 4'd15) begin
                    state_d     = swap_pend_q ? ST_WAIT_SWAP : ST_IDLE;
                    swap_pend_d = 1'b0;
                end
            end
            ST_WAIT_SWAP: begin
                // Same edge on which the driver's row counter wraps to row 0.
                if (frame_end) begin
                    front_d = !front_q;
                    state_d = ST_SWAP;
                end
            end
            ST_SWAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Back-buffer update: row clear in CLEAR, single granted pixel write in IDLE
    always_comb begin
        red0_d = red0_q;
        grn0_d = grn0_q;
        red1_d = red1_q;
        grn1_d = grn1_q;
        if (state_q == ST_CLEAR) begin
            if (front_q) begin
                red0_d[ptr_q] = '0;
                grn0_d[ptr_q] = '0;
            end else begin
                red1_d[ptr_q] = '0;
                grn1_d[ptr_q] = '0;
            end
        end
        if (wr_en) begin
            if (front_q) begin
                red0_d[wr_row][wr_col] = wr_red;
                grn0_d[wr_row][wr_col] = wr_grn;
            end else begin
                red1_d[wr_row][wr_col] = wr_red;
                grn1_d[wr_row][wr_col] = wr_grn;
            end
        end
    end

    // Control registers
    always_ff @(posedge CLK or negedge RST_n) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge value of every other flop, independent of statement order.
        if (!RST_n) begin
            state_q     <= ST_IDLE;
            tick_q      <= '0;
            pulse_q     <= '0;
            front_q     <= 1'b0;
            ptr_q       <= 4'd0;
            lg_q        <= LG_B;
            swap_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            pulse_q     <= pulse_d;
            front_q     <= front_d;
            ptr_q       <= ptr_d;
            lg_q        <= lg_d;
            swap_pend_q <= swap_pend_d;
        end
    end

    // Pixel storage for both buffers
    always_ff @(posedge CLK or negedge RST_n) begin
        // NOTE: the buffers are flops, not a RAM macro, and they are reset so
        // that a reset in the middle of a clear or a pending swap leaves the
        // driver showing a defined, all-dark frame.
        if (!RST_n) begin
            red0_q <= '0;
            grn0_q <= '0;
            red1_q <= '0;
            grn1_q <= '0;
        end else begin
            red0_q <= red0_d;
            grn0_q <= grn0_d;
            red1_q <= red1_d;
            grn1_q <= grn1_d;
        end
    end

    assign bus.A_ready    = grant_a;
    assign bus.B_ready    = grant_b;
    assign bus.Busy       = !idle;
    assign bus.Swap_done  = (state_q == ST_SWAP);
    assign bus.ScanEnable = scan_en;
    assign bus.FrameStart = frame_end;
    assign bus.RedPixels  = front_q ? red1_q : red0_q;
    assign bus.GrnPixels  = front_q ? grn1_q : grn0_q;

endmodule

// File: doc/led_frame_scheduler.md
# led_frame_scheduler

Double-buffered frame controller for the 16x16x2 LED display driver. Two requesters write red/green pixels into a back buffer through a round-robin arbiter. The block also generates the driver's row-advance enable pulse, and presents the front buffer to the driver's pixel inputs. A swap of front and back buffers happens only on a frame boundary, so the display never shows a half-drawn frame.

## Interface

Parameters:
- TICKDIV, 1000, clock cycles between ScanEnable pulses (≥2).
- FREQDIV, 0, must equal the driver's FREQDIV. The driver changes row every 2^FREQDIV ScanEnable pulses.

Ports (clock and reset first; all requester inputs are synchronous to CLK):
- CLK  in  1  system clock.
- RST_n  in  1  reset, asynchronous, active-low. The driver's RST must be asserted by the same reset event.
- A_valid  in  1  requester A write request.
- A_ready  out  1  A write accepted this cycle.
- A_row, A_col  in  4 each  A target pixel.
- A_red, A_grn  in  1 each  A pixel values.
- B_valid, B_ready, B_row, B_col, B_red, B_grn  same as A, for requester B.
- Clear_req  in  1  pulse: zero the back buffer.
- Swap_req  in  1  pulse: present the back buffer at the next frame boundary.
- Busy  out  1  state ≠ IDLE.
- Swap_done  out  1  one-cycle pulse, the cycle after a swap.
- ScanEnable  out  1  to driver Enablecurr_count; one-cycle pulse.
- FrameStart  out  1  one-cycle pulse coincident with the frame-end ScanEnable.
- RedPixels, GrnPixels  out  [15:0][15:0]  front buffer, indexed [row][col], to the driver.

## Operation

- Storage: buffers buf0 and buf1, each holding red 16x16 and green 16x16. The `front` bit selects the displayed buffer; the other buffer is the back buffer. Outputs are a combinational mux of registered storage.
- Tick counter counts 0..TICKDIV-1 and wraps. ScanEnable = 1 when the counter equals TICKDIV-1.
- Pulse counter is FREQDIV+4 bits and increments on each ScanEnable, wrapping naturally. FrameEnd = ScanEnable && (pulse counter is all ones). FrameStart = FrameEnd.
- State machine:
  - IDLE:
    - Arbitration is enabled.
    - Clear_req → CLEAR with row pointer = 0.
    - Otherwise Swap_req → WAIT_SWAP.
    - If Clear_req and Swap_req arrive together, Clear wins and the swap is latched. After the clear finishes, the machine goes to WAIT_SWAP.
  - CLEAR:
    - Each cycle zeroes back-buffer red and green for row `ptr`, then ptr+1.
    - At ptr=15: go to WAIT_SWAP if a swap is latched, else IDLE.
    - Takes exactly 16 cycles.
  - WAIT_SWAP: on FrameEnd, toggle `front` and go to SWAP.
  - SWAP: assert Swap_done for 1 cycle, then IDLE.
- Clear_req and Swap_req are ignored whenever Busy=1 (except the latched case above).
- Arbitration (IDLE only):
  - A_ready/B_ready are combinational from the valids, state and the last-grant pointer `lg`.
  - Only one requester is granted per cycle.
  - Both valid: grant the requester that is not `lg`.
  - Single valid: grant it.
  - `lg` updates to the granted requester.
  - Granted write: on the clock edge, back-buffer red[row][col] ← red and grn[row][col] ← grn.
  - Both readies are 0 outside IDLE. A requester holds valid and payload until it sees ready.
- The back buffer is not copied on a swap. After a swap, the back buffer holds the previous front frame.

## Timing

- Reset (asynchronous assert, synchronous release): both buffers all zero, front=0, tick=0, pulse=0, ptr=0, lg=B (so A wins the first tie), swap latch=0, state IDLE. Outputs at reset: ScanEnable=0, FrameStart=0, Swap_done=0, Busy=0, A_ready=B_ready=0.
- ScanEnable first asserts in cycle TICKDIV-1 after reset release, then every TICKDIV cycles.
- A frame is 16·2^FREQDIV·TICKDIV cycles.
- Write latency is 0 to storage (the accept edge). A write is visible on RedPixels/GrnPixels only after a subsequent swap.
- Swap edge is the same edge on which the driver's counter wraps to 0, so row 0 of the new frame is the first row shown. Swap_done asserts on the next cycle.
- Swap_req to Swap_done, worst case: 16 (clear) + one frame + 2 cycles.
- Swap_req in the FrameEnd cycle: the machine enters WAIT_SWAP after that edge and waits a full frame (no same-cycle swap).
- Reset asserted mid-CLEAR or mid-WAIT_SWAP: all state returns to the reset values immediately, and no partial swap is visible.

## Test plan

- **Reset and scan:** TICKDIV=4, FREQDIV=0; release reset → ScanEnable pulses at cycles 3, 7, 11…; FrameStart at the 16th pulse (cycle 63); outputs all zero.
- **Write then swap:** A writes (2,3) red=1, then Swap_req → RedPixels[2][3] stays 0 until the FrameEnd edge, then reads 1; Swap_done follows one cycle later; Busy is high from the Swap_req edge through Swap_done.
- **Contention:** A and B both valid continuously for 4 cycles with distinct pixels → grants A, B, A, B; exactly 4 pixels are written; the readies are never both 1.
- **Clear plus swap together:** back buffer full of ones; Clear_req and Swap_req in the same cycle → Busy for 16 cycles of clear, then WAIT_SWAP; after the swap the displayed frame is all zeros; ready=0 throughout.
- **Ignored requests:** Swap_req while in WAIT_SWAP → only one swap and one Swap_done; a write during WAIT_SWAP is stalled and accepted in the first IDLE cycle.
- **Reset mid-operation:** assert RST_n low during CLEAR at ptr=7 → immediate reset values; after release, Busy=0 and front=0.
